// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request bus between the fetch stage (master) and imem (slave).
// Handshake: imem_req/imem_addr hold steady until a cycle where imem_req && imem_ready; that cycle transfers imem_rdata.
interface if_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/if_fetch_unit.sv
// MIPS instruction-fetch stage: owns the PC, fetches over the imem bus and feeds IF/ID.
// Branch/jump redirects take effect after the delay-slot instruction has been delivered.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_pc,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            Ins_out,
    output logic [31:0]            nextAddress_out,
    output logic                   IRWrite,
    output logic                   fetch_valid,
    output logic                   addr_exc,
    output logic                   state_dbg
);

    typedef enum logic {
        S_REQ   = 1'b0,
        S_VALID = 1'b1
    } fetch_state_e;

    fetch_state_e state;
    logic [31:0]  pc;
    logic [31:0]  ins_hold;
    logic         exc_hold;
    logic         pend_valid;
    logic [31:0]  pend_pc;

    logic         pc_misaligned;
    logic         accept;
    logic         redirect_live;
    logic [31:0]  pc_plus4;

    assign pc_misaligned = |pc[1:0];
    assign pc_plus4      = pc + 32'd4;
    assign accept        = (state == S_VALID) && !stall;
    assign redirect_live = redirect && !stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            ins_hold   <= NOP_WORD;
            exc_hold   <= 1'b0;
            pend_valid <= 1'b0;
            pend_pc    <= RESET_PC;
        end else begin
            case (state)
                S_REQ: begin
                    // A misaligned PC never reaches memory; it becomes a NOP flagged as an exception.
                    if (pc_misaligned) begin
                        state    <= S_VALID;
                        exc_hold <= 1'b1;
                        ins_hold <= NOP_WORD;
                    end else if (imem.imem_ready) begin
                        state    <= S_VALID;
                        exc_hold <= 1'b0;
                        ins_hold <= imem.imem_rdata;
                    end
                    // The in-flight fetch is the delay slot, so the target waits until it is accepted.
                    if (redirect_live) begin
                        pend_valid <= 1'b1;
                        pend_pc    <= redirect_pc;
                    end
                end
                S_VALID: begin
                    if (!stall) begin
                        state      <= S_REQ;
                        exc_hold   <= 1'b0;
                        pend_valid <= 1'b0;
                        if (redirect) begin
                            pc <= redirect_pc;
                        end else if (pend_valid) begin
                            pc <= pend_pc;
                        end else begin
                            pc <= pc_plus4;
                        end
                    end
                end
                default: begin
                    state <= S_REQ;
                end
            endcase
        end
    end

    // The request is withdrawn in a reset cycle so memory drops it cleanly.
    assign imem.imem_req  = (state == S_REQ) && !pc_misaligned && !reset;
    assign imem.imem_addr = pc;

    assign fetch_valid     = (state == S_VALID);
    assign Ins_out         = (state == S_VALID) ? ins_hold : NOP_WORD;
    assign addr_exc        = (state == S_VALID) && exc_hold;
    assign IRWrite         = accept;
    assign nextAddress_out = pc_plus4;
    assign state_dbg       = (state == S_VALID);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomised bench for if_fetch_unit: a stream-level model predicts the delivered
// instruction sequence (PC order, delay slots, exceptions) and a monitor checks it.
module tb_if_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic [31:0] ins_out;
    logic [31:0] next_address_out;
    logic        ir_write;
    logic        fetch_valid;
    logic        addr_exc;
    logic        state_dbg;

    if_fetch_unit_if imem_bus();

    if_fetch_unit #(
        .RESET_PC(RESET_PC),
        .NOP_WORD(NOP_WORD)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .imem            (imem_bus),
        .Ins_out         (ins_out),
        .nextAddress_out (next_address_out),
        .IRWrite         (ir_write),
        .fetch_valid     (fetch_valid),
        .addr_exc        (addr_exc),
        .state_dbg       (state_dbg)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    int lat_min = 0;
    int lat_max = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F2E};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    // ---------------- memory responder ----------------
    int wait_cnt = 0;
    int cur_lat = 0;
    initial begin
        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (imem_bus.imem_req === 1'b1) begin
                if (wait_cnt == 0) cur_lat = $urandom_range(lat_max, lat_min);
                if (wait_cnt >= cur_lat) begin
                    imem_bus.imem_ready = 1'b1;
                    imem_bus.imem_rdata = mem_word(imem_bus.imem_addr);
                    wait_cnt = 0;
                end else begin
                    imem_bus.imem_ready = 1'b0;
                    imem_bus.imem_rdata = $urandom;
                    wait_cnt++;
                end
            end else begin
                imem_bus.imem_ready = $urandom_range(0, 1) == 1;
                imem_bus.imem_rdata = $urandom;
                wait_cnt = 0;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    // exp_q holds the PC of the instruction the stage is expected to deliver next.
    logic [31:0] exp_q[$];
    logic [31:0] pend_target = 32'h0;
    bit          pend = 1'b0;
    bit          armed = 1'b0;
    bit          after_reset = 1'b0;
    bit          prev_ir = 1'b0;
    int          idle = 0;

    initial begin
        logic [31:0] cur;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                check32("req_during_reset", {31'b0, imem_bus.imem_req}, 32'd0);
                exp_q.delete();
                exp_q.push_back(RESET_PC);
                pend = 1'b0;
                armed = 1'b1;
                after_reset = 1'b1;
                prev_ir = 1'b0;
                idle = 0;
            end else if (armed) begin
                if (after_reset) begin
                    check32("rst_imem_req", {31'b0, imem_bus.imem_req}, 32'd1);
                    check32("rst_imem_addr", imem_bus.imem_addr, RESET_PC);
                    check32("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
                    check32("rst_irwrite", {31'b0, ir_write}, 32'd0);
                    check32("rst_ins_out", ins_out, NOP_WORD);
                    check32("rst_addr_exc", {31'b0, addr_exc}, 32'd0);
                    after_reset = 1'b0;
                end
                check32("next_address", next_address_out, exp_q[0] + 32'd4);
                check32("irwrite_rule", {31'b0, ir_write}, {31'b0, fetch_valid & ~stall});
                if (!fetch_valid) begin
                    check32("idle_ins_nop", ins_out, NOP_WORD);
                    check32("idle_addr_exc", {31'b0, addr_exc}, 32'd0);
                    check32("req_when_fetching", {31'b0, imem_bus.imem_req},
                            {31'b0, exp_q[0][1:0] == 2'b00});
                end else begin
                    check32("req_when_valid", {31'b0, imem_bus.imem_req}, 32'd0);
                end
                if (imem_bus.imem_req) check32("imem_addr", imem_bus.imem_addr, exp_q[0]);
                if (prev_ir) check32("throughput", {31'b0, ir_write}, 32'd0);
                if (redirect && !stall) begin
                    pend = 1'b1;
                    pend_target = redirect_pc;
                end
                if (ir_write) begin
                    cur = exp_q.pop_front();
                    check32("ins_out", ins_out, (cur[1:0] == 2'b00) ? mem_word(cur) : NOP_WORD);
                    check32("addr_exc", {31'b0, addr_exc}, {31'b0, cur[1:0] != 2'b00});
                    exp_q.push_back(pend ? pend_target : cur + 32'd4);
                    pend = 1'b0;
                    idle = 0;
                end else begin
                    idle++;
                end
                if (idle > 60) begin
                    checks++;
                    failures++;
                    $display("FAIL watchdog actual=no_delivery_for_%0d_cycles required=delivery", idle);
                    idle = 0;
                end
                prev_ir = ir_write;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input bit r, input bit s, input bit rd, input logic [31:0] rpc);
        @(negedge clk);
        reset = r;
        stall = s;
        redirect = rd;
        redirect_pc = rpc;
    endtask

    task automatic run_idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic redirect_in_req(input logic [31:0] rpc);
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            reset = 1'b0;
            stall = 1'b0;
            if (!fetch_valid) begin
                redirect = 1'b1;
                redirect_pc = rpc;
                done = 1'b1;
            end else begin
                redirect = 1'b0;
            end
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL redirect_in_req actual=no_fetch_state required=fetch_state");
        end
    endtask

    task automatic stall_in_valid(input int n);
        bit done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            reset = 1'b0;
            redirect = 1'b0;
            stall = fetch_valid;
            done = fetch_valid;
        end
        repeat (n - 1) step(1'b0, 1'b1, 1'b0, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] tgt;
        int          pick;

        // zero-latency memory, free-running fetch from reset
        lat_min = 0; lat_max = 0;
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        run_idle(8);

        // slow memory and a 4-cycle stall while holding an instruction
        lat_min = 3; lat_max = 3;
        run_idle(3);
        stall_in_valid(4);
        run_idle(10);

        // delay slot: redirect while a fetch is in flight
        lat_min = 0; lat_max = 2;
        redirect_in_req(32'h0000_3100);
        run_idle(6);

        // two redirects before accept, last wins; redirect under stall ignored
        lat_min = 3; lat_max = 3;
        redirect_in_req(32'h0000_3100);
        step(1'b0, 1'b0, 1'b1, 32'h0000_3200);
        step(1'b0, 1'b1, 1'b1, 32'h0000_3300);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        run_idle(12);

        // misaligned target
        lat_min = 0; lat_max = 1;
        redirect_in_req(32'h0000_3102);
        run_idle(6);
        redirect_in_req(32'h0000_3000);
        run_idle(6);

        // PC wrap, then reset while a request waits on memory
        redirect_in_req(32'hFFFF_FFFC);
        run_idle(8);
        lat_min = 8; lat_max = 8;
        for (int i = 0; i < 20 && imem_bus.imem_req !== 1'b1; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        run_idle(2);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        lat_min = 0; lat_max = 3;
        run_idle(8);

        // randomised traffic
        for (int i = 0; i < 1500; i++) begin
            pick = $urandom_range(0, 9);
            if (pick == 0)      tgt = 32'h0000_3002 + ($urandom_range(0, 255) << 2);
            else if (pick == 1) tgt = ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFC : 32'hFFFF_FFF8;
            else                tgt = 32'h0000_3000 + ($urandom_range(0, 1023) << 2);
            step($urandom_range(0, 399) == 0,
                 $urandom_range(0, 99) < 25,
                 $urandom_range(0, 99) < 15,
                 tgt);
        end
        run_idle(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end
endmodule
